// File: rtl/rvc_pkg.sv
// Shared RV32I / RVC encoding constants and the compressor state type.
package rvc_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] CQ0 = 2'b00;
  localparam logic [1:0] CQ1 = 2'b01;
  localparam logic [1:0] CQ2 = 2'b10;

  localparam logic [2:0] CF3_ADDI4SPN = 3'b000;
  localparam logic [2:0] CF3_ADDI     = 3'b000;
  localparam logic [2:0] CF3_LI       = 3'b010;
  localparam logic [2:0] CF3_LUI      = 3'b011;
  localparam logic [2:0] CF3_ALU      = 3'b100;
  localparam logic [2:0] CF3_SLLI     = 3'b000;
  localparam logic [2:0] CF3_CR       = 3'b100;

  localparam logic [1:0] CF2_SRLI = 2'b00;
  localparam logic [1:0] CF2_SRAI = 2'b01;
  localparam logic [1:0] CF2_ANDI = 2'b10;
  localparam logic [1:0] CF2_CA   = 2'b11;

  localparam logic [1:0] CA_SUB = 2'b00;
  localparam logic [1:0] CA_XOR = 2'b01;
  localparam logic [1:0] CA_OR  = 2'b10;
  localparam logic [1:0] CA_AND = 2'b11;

  localparam logic [15:0] C_NOP = 16'h0001;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HOLD_LO = 2'd1,
    HOLD_HI = 2'd2
  } state_t;

endpackage

// File: rtl/rvc_compress_encode.sv
// Combinational RV32I -> RVC encoder; first matching rule wins.
// c.addi16sp / c.addi4spn exist only when RVC_COMPRESSOR_SP_EN is defined.
module rvc_compress_encode
  import rvc_pkg::*;
(
  input  logic [31:0] in_inst,
  output logic        compressible,
  output logic [15:0] c_half
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm;
  logic        imm6_ok;
  logic        rd_p;
  logic        rs1_p;
  logic        rs2_p;

  assign opcode  = in_inst[6:0];
  assign rd      = in_inst[11:7];
  assign f3      = in_inst[14:12];
  assign rs1     = in_inst[19:15];
  assign rs2     = in_inst[24:20];
  assign f7      = in_inst[31:25];
  assign imm     = in_inst[31:20];
  assign imm6_ok = (in_inst[31:25] == {7{in_inst[25]}});
  assign rd_p    = (rd[4:3] == 2'b01);
  assign rs1_p   = (rs1[4:3] == 2'b01);
  assign rs2_p   = (rs2[4:3] == 2'b01);

  always_comb begin
    compressible = 1'b0;
    c_half       = '0;
    if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd == '0 && rs1 == '0 && imm == '0) begin
      compressible = 1'b1;
      c_half       = C_NOP;
    end else if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd != '0 && rs1 == '0 && imm6_ok) begin
      compressible = 1'b1;
      c_half       = {CF3_LI, imm[5], rd, imm[4:0], CQ1};
    end else if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd == rs1 && rd != '0
                 && imm != '0 && imm6_ok) begin
      compressible = 1'b1;
      c_half       = {CF3_ADDI, imm[5], rd, imm[4:0], CQ1};
`ifdef RVC_COMPRESSOR_SP_EN
    end else if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd == 5'd2 && rs1 == 5'd2
                 && imm != '0 && imm[3:0] == '0 && imm[11:9] == {3{imm[9]}}) begin
      compressible = 1'b1;
      c_half       = {CF3_LUI, imm[9], 5'd2, imm[4], imm[6], imm[8:7], imm[5], CQ1};
    end else if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd_p && rs1 == 5'd2
                 && imm != '0 && imm[1:0] == '0 && imm[11:10] == '0) begin
      compressible = 1'b1;
      c_half       = {CF3_ADDI4SPN, imm[5:4], imm[9:6], imm[2], imm[3], rd[2:0], CQ0};
`endif
    end else if (opcode == OPC_OP_IMM && f3 == F3_ADD && rd != '0 && rs1 != '0 && imm == '0) begin
      compressible = 1'b1;
      c_half       = {CF3_CR, 1'b0, rd, rs1, CQ2};
    end else if (opcode == OPC_LUI && rd != '0 && rd != 5'd2
                 && in_inst[31:17] == {15{in_inst[17]}} && in_inst[17:12] != '0) begin
      compressible = 1'b1;
      c_half       = {CF3_LUI, in_inst[17], rd, in_inst[16:12], CQ1};
    end else if (opcode == OPC_OP && f3 == F3_ADD && f7 == F7_BASE
                 && rd == rs1 && rd != '0 && rs2 != '0) begin
      compressible = 1'b1;
      c_half       = {CF3_CR, 1'b1, rd, rs2, CQ2};
    end else if (opcode == OPC_OP && f3 == F3_ADD && f7 == F7_BASE
                 && rd != '0 && rs1 == '0 && rs2 != '0) begin
      compressible = 1'b1;
      c_half       = {CF3_CR, 1'b0, rd, rs2, CQ2};
    end else if (opcode == OPC_OP_IMM && f3 == F3_SLL && f7 == F7_BASE
                 && rd == rs1 && rd != '0 && rs2 != '0) begin
      compressible = 1'b1;
      c_half       = {CF3_SLLI, 1'b0, rd, rs2, CQ2};
    end else if (opcode == OPC_OP_IMM && f3 == F3_SR && (f7 == F7_BASE || f7 == F7_ALT)
                 && rd == rs1 && rd_p && rs2 != '0) begin
      compressible = 1'b1;
      c_half       = {CF3_ALU, 1'b0, (f7 == F7_ALT) ? CF2_SRAI : CF2_SRLI, rd[2:0], rs2, CQ1};
    end else if (opcode == OPC_OP_IMM && f3 == F3_AND && rd == rs1 && rd_p && imm6_ok) begin
      compressible = 1'b1;
      c_half       = {CF3_ALU, imm[5], CF2_ANDI, rd[2:0], imm[4:0], CQ1};
    end else if (opcode == OPC_OP && rd == rs1 && rd_p && rs1_p && rs2_p) begin
      compressible = 1'b1;
      if (f3 == F3_ADD && f7 == F7_ALT)
        c_half = {CF3_ALU, 1'b0, CF2_CA, rd[2:0], CA_SUB, rs2[2:0], CQ1};
      else if (f3 == F3_XOR && f7 == F7_BASE)
        c_half = {CF3_ALU, 1'b0, CF2_CA, rd[2:0], CA_XOR, rs2[2:0], CQ1};
      else if (f3 == F3_OR && f7 == F7_BASE)
        c_half = {CF3_ALU, 1'b0, CF2_CA, rd[2:0], CA_OR, rs2[2:0], CQ1};
      else if (f3 == F3_AND && f7 == F7_BASE)
        c_half = {CF3_ALU, 1'b0, CF2_CA, rd[2:0], CA_AND, rs2[2:0], CQ1};
      else
        compressible = 1'b0;
    end
  end

endmodule

// File: rtl/rvc_compressor.sv
// Streaming RV32I-to-RVC compressor: one parcel per compressible instruction, else two.
// Optional SP-relative forms enabled by defining RVC_COMPRESSOR_SP_EN.
module rvc_compressor
  import rvc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_half,
  output logic        out_first,
  output logic        out_compressed
);

  state_t      state;
  state_t      state_next;
  logic [15:0] hi_reg;
  logic [15:0] hi_next;
  logic [15:0] half_next;
  logic        first_next;
  logic        comp_next;
  logic        compressible;
  logic [15:0] c_half;
  logic        accept;
  logic        xfer;

  rvc_compress_encode u_encode (
    .in_inst      (in_inst),
    .compressible (compressible),
    .c_half       (c_half)
  );

  assign out_valid = (state != EMPTY);
  assign in_ready  = !reset && ((state == EMPTY) ||
                     (out_ready && ((state == HOLD_HI) || (state == HOLD_LO && out_compressed))));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_next = state;
    hi_next    = hi_reg;
    half_next  = out_half;
    first_next = out_first;
    comp_next  = out_compressed;
    unique case (state)
      EMPTY: ;
      HOLD_LO:
        if (xfer) begin
          if (!out_compressed) begin
            state_next = HOLD_HI;
            half_next  = hi_reg;
            first_next = 1'b0;
            comp_next  = 1'b0;
          end else begin
            state_next = EMPTY;
          end
        end
      HOLD_HI:
        if (xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    // in_ready already implies the held parcel is leaving, so a load overrides the above
    if (accept) begin
      state_next = HOLD_LO;
      half_next  = compressible ? c_half : in_inst[15:0];
      first_next = 1'b1;
      comp_next  = compressible;
      if (!compressible) hi_next = in_inst[31:16];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= EMPTY;
      hi_reg         <= '0;
      out_half       <= '0;
      out_first      <= 1'b0;
      out_compressed <= 1'b0;
    end else begin
      state          <= state_next;
      hi_reg         <= hi_next;
      out_half       <= half_next;
      out_first      <= first_next;
      out_compressed <= comp_next;
    end
  end

endmodule

// File: tb/tb_rvc_compressor.sv
// Directed self-checking bench for rvc_compressor with hand-encoded RVC results.
module tb_rvc_compressor;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_half;
  logic        out_first;
  logic        out_compressed;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        comp;
  } vec_t;

  vec_t vecs [12];

  always #5 clock = ~clock;

  rvc_compressor dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_half       (out_half),
    .out_first      (out_first),
    .out_compressed (out_compressed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_parcel(input string tag, input logic [15:0] half,
                               input logic first, input logic comp);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".half"},  {16'b0, out_half}, {16'b0, half});
    check({tag, ".first"}, {31'b0, out_first}, {31'b0, first});
    check({tag, ".comp"},  {31'b0, out_compressed}, {31'b0, comp});
  endtask

  initial begin
    vecs[0]  = '{32'h00000013, 16'h0001, 16'h0000, 1'b1};
    vecs[1]  = '{32'hFFF50513, 16'h157D, 16'h0000, 1'b1};
    vecs[2]  = '{32'h00058513, 16'h852E, 16'h0000, 1'b1};
    vecs[3]  = '{32'h00001537, 16'h6505, 16'h0000, 1'b1};
    vecs[4]  = '{32'h00001137, 16'h1137, 16'h0000, 1'b0};
    vecs[5]  = '{32'h00351513, 16'h050E, 16'h0000, 1'b1};
    vecs[6]  = '{32'h40245413, 16'h8409, 16'h0000, 1'b1};
    vecs[7]  = '{32'hFFC4F493, 16'h98F1, 16'h0000, 1'b1};
    vecs[8]  = '{32'h0084E4B3, 16'h8CC1, 16'h0000, 1'b1};
    vecs[9]  = '{32'h00004515, 16'h4515, 16'h0000, 1'b0};
`ifdef RVC_COMPRESSOR_SP_EN
    vecs[10] = '{32'hFC010113, 16'h7139, 16'h0000, 1'b1};
    vecs[11] = '{32'h01010413, 16'h0800, 16'h0000, 1'b1};
`else
    vecs[10] = '{32'hFC010113, 16'h0113, 16'hFC01, 1'b0};
    vecs[11] = '{32'h01010413, 16'h0413, 16'h0101, 1'b0};
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst.half", {16'b0, out_half}, 32'd0);
    check("rst.first", {31'b0, out_first}, 32'd0);
    check("rst.comp", {31'b0, out_compressed}, 32'd0);
    check("idle.in_ready", {31'b0, in_ready}, 32'd1);

    // c.li single parcel, one cycle after accept
    in_valid = 1'b1; in_inst = 32'h00500513; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    expect_parcel("li", 16'h4515, 1'b1, 1'b1);
    step();
    check("li.drain", {31'b0, out_valid}, 32'd0);

    // back-to-back compressed: add then sub
    in_valid = 1'b1; in_inst = 32'h00B50533;
    step();
    in_inst = 32'h40940433;
    #1;
    expect_parcel("add", 16'h952E, 1'b1, 1'b1);
    check("b2b.in_ready0", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    expect_parcel("sub", 16'h8C05, 1'b1, 1'b1);
    check("b2b.in_ready1", {31'b0, in_ready}, 32'd1);
    step();
    check("b2b.drain", {31'b0, out_valid}, 32'd0);

    // uncompressed two-parcel instruction
    in_valid = 1'b1; in_inst = 32'h06458513;
    step();
    in_valid = 1'b0;
    #1;
    expect_parcel("unc.lo", 16'h8513, 1'b1, 1'b0);
    check("unc.in_ready_lo", {31'b0, in_ready}, 32'd0);
    step();
    expect_parcel("unc.hi", 16'h0645, 1'b0, 1'b0);
    check("unc.in_ready_hi", {31'b0, in_ready}, 32'd1);
    step();
    check("unc.drain", {31'b0, out_valid}, 32'd0);

    // rule table
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      expect_parcel($sformatf("vec%0d.lo", i), vecs[i].lo, 1'b1, vecs[i].comp);
      if (!vecs[i].comp) begin
        step();
        expect_parcel($sformatf("vec%0d.hi", i), vecs[i].hi, 1'b0, 1'b0);
      end
      step();
      check($sformatf("vec%0d.drain", i), {31'b0, out_valid}, 32'd0);
    end

    // stall: output held while out_ready low
    in_valid = 1'b1; in_inst = 32'h00500513; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_parcel($sformatf("stall%0d", i), 16'h4515, 1'b1, 1'b1);
      check($sformatf("stall%0d.in_ready", i), {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    expect_parcel("stall.release", 16'h4515, 1'b1, 1'b1);
    check("stall.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("stall.drain", {31'b0, out_valid}, 32'd0);

    // reset in HOLD_HI discards the high half
    in_valid = 1'b1; in_inst = 32'h06458513; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    expect_parcel("rsthi.hi", 16'h0645, 1'b0, 1'b0);
    reset = 1'b1; out_ready = 1'b0;
    #1;
    check("rsthi.in_ready", {31'b0, in_ready}, 32'd0);
    step();
    check("rsthi.valid", {31'b0, out_valid}, 32'd0);
    check("rsthi.half", {16'b0, out_half}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rsthi.quiet%0d", i), {31'b0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
